// File: rtl/ysyx_24100006_lsu.sv
// Load/store unit: one instruction per handshake, at most one bus access, formatted GPR write-data out.
// Optional macro YSYX_LSU_MISALIGN_CHECK_EN faults misaligned H/W accesses without touching the bus.
module ysyx_24100006_lsu #(
    parameter int CTRL_W = 24,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [2:0]        mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    input  logic [31:0]       alu_result,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       wdata_gpr_M,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              mem_fault,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_we,
    output logic [ADDR_W-1:0] req_addr,
    output logic [31:0]       req_wdata,
    output logic [3:0]        req_wstrb,
    input  logic              rsp_valid,
    input  logic [31:0]       rsp_rdata,
    input  logic              rsp_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic        load_q;
    logic [31:0] alu_q;

    logic        accept;
    logic        is_mem;
    logic        misalign;
    logic        bus_go;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign accept = in_valid && in_ready;
    assign is_mem = mem_ren || mem_wen;

`ifdef YSYX_LSU_MISALIGN_CHECK_EN
    assign misalign = is_mem &&
                      (((mem_op[1:0] == 2'b01) && addr[0]) ||
                       ((mem_op[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign bus_go = is_mem && !misalign;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = bus_go ? REQ : DONE;
            REQ:  if (req_ready) state_nxt = WAIT;
            WAIT: if (rsp_valid) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state == IDLE) && !reset;
        req_valid = (state == REQ);
        out_valid = (state == DONE);
    end

    always_comb begin
        st_wdata = store_data;
        st_wstrb = 4'b1111;
        case (mem_op[1:0])
            2'b00: begin
                st_wdata = {4{store_data[7:0]}};
                st_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                st_wdata = {2{store_data[15:0]}};
                st_wstrb = 4'b0011 << {addr[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (lane_q)
            2'd0:    ld_byte = rsp_rdata[7:0];
            2'd1:    ld_byte = rsp_rdata[15:8];
            2'd2:    ld_byte = rsp_rdata[23:16];
            default: ld_byte = rsp_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
        case (op_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = rsp_rdata;
        endcase
    end

    // Request fields are captured at accept so they stay stable through REQ
    always_ff @(posedge clk) begin
        if (reset) begin
            wdata_gpr_M <= '0;
            ctrl_o      <= '0;
            mem_fault   <= 1'b0;
            req_we      <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            req_wstrb   <= '0;
            op_q        <= '0;
            lane_q      <= '0;
            load_q      <= 1'b0;
            alu_q       <= '0;
        end else if (accept) begin
            ctrl_o      <= ctrl_i;
            op_q        <= mem_op;
            lane_q      <= addr[1:0];
            load_q      <= mem_ren;
            alu_q       <= alu_result;
            mem_fault   <= misalign;
            wdata_gpr_M <= is_mem ? 32'd0 : alu_result;
            req_addr    <= {addr[ADDR_W-1:2], 2'b00};
            req_we      <= mem_wen && !mem_ren;
            req_wdata   <= (mem_wen && !mem_ren) ? st_wdata : 32'd0;
            req_wstrb   <= (mem_wen && !mem_ren) ? st_wstrb : 4'b0000;
        end else if ((state == WAIT) && rsp_valid) begin
            mem_fault   <= rsp_err;
            wdata_gpr_M <= rsp_err ? 32'd0 : (load_q ? ld_data : alu_q);
        end
    end

endmodule

// File: tb/tb_ysyx_24100006_lsu.sv
// Randomized bench for ysyx_24100006_lsu against a transaction-level reference model.
module tb_ysyx_24100006_lsu;
    localparam int CTRL_W = 24;
    localparam int ADDR_W = 32;

    logic              clk, reset;
    logic              in_valid, in_ready;
    logic              mem_ren, mem_wen;
    logic [2:0]        mem_op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       store_data, alu_result;
    logic [CTRL_W-1:0] ctrl_i, ctrl_o;
    logic              out_valid, out_ready;
    logic [31:0]       wdata_gpr_M;
    logic              mem_fault;
    logic              req_valid, req_ready, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              rsp_valid, rsp_err;
    logic [31:0]       rsp_rdata;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_24100006_lsu #(.CTRL_W(CTRL_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_op(mem_op), .addr(addr),
        .store_data(store_data), .alu_result(alu_result), .ctrl_i(ctrl_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .wdata_gpr_M(wdata_gpr_M), .ctrl_o(ctrl_o), .mem_fault(mem_fault),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] op, input int unsigned a, input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        case (op)
            3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] op, input int unsigned a);
        case (op % 4)
            0:       return 4'(1 << a);
            1:       return 4'(3 << (2 * (a / 2)));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] d);
        case (op % 4)
            0:       return (d & 32'hFF) * 32'h01010101;
            1:       return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] op, input int unsigned a);
`ifdef YSYX_LSU_MISALIGN_CHECK_EN
        return ((op % 4 == 1) && (a % 2 != 0)) || ((op % 4 == 2) && (a != 0));
`else
        return 1'b0;
`endif
    endfunction

    task automatic run_txn(input bit ren, input bit wen, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] alu, input logic [CTRL_W-1:0] ctl,
                           input int rq_dly, input int rsp_dly, input logic [31:0] rdata, input bit err,
                           input int out_dly, input bit junk);
        int unsigned lane;
        bit          mem, mis, go_bus, exp_we, exp_fault;
        logic [31:0] exp_data;
        int          guard;
        lane   = a % 4;
        mem    = ren || wen;
        mis    = mem && ref_misaligned(op, lane);
        go_bus = mem && !mis;
        exp_we = wen && !ren;

        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);

        in_valid = 1'b1; mem_ren = ren; mem_wen = wen; mem_op = op; addr = a;
        store_data = sd; alu_result = alu; ctrl_i = ctl;
        tick();
        in_valid = 1'b0; mem_ren = 1'($urandom); mem_wen = 1'($urandom); mem_op = 3'($urandom);
        addr = $urandom; store_data = $urandom; alu_result = $urandom; ctrl_i = CTRL_W'($urandom);

        if (go_bus) begin
            check("req_valid", {31'd0, req_valid}, 32'd1);
            check("out_valid_early", {31'd0, out_valid}, 32'd0);
            check("req_addr", req_addr, a & 32'hFFFFFFFC);
            check("req_we", {31'd0, req_we}, {31'd0, exp_we});
            check("req_wstrb", {28'd0, req_wstrb}, exp_we ? {28'd0, ref_strb(op, lane)} : 32'd0);
            if (exp_we) check("req_wdata", req_wdata, ref_wdata(op, sd));
            for (int i = 0; i < rq_dly; i++) begin
                tick();
                check("req_hold_valid", {31'd0, req_valid}, 32'd1);
                check("req_hold_addr", req_addr, a & 32'hFFFFFFFC);
                check("req_hold_strb", {28'd0, req_wstrb}, exp_we ? {28'd0, ref_strb(op, lane)} : 32'd0);
            end
            req_ready = 1'b1;
            if (junk) begin
                rsp_valid = 1'b1; rsp_rdata = $urandom; rsp_err = 1'b1;
            end
            tick();
            req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
            check("req_dropped", {31'd0, req_valid}, 32'd0);
            check("wait_no_out", {31'd0, out_valid}, 32'd0);
            for (int i = 0; i < rsp_dly; i++) tick();
            check("wait_still", {31'd0, out_valid}, 32'd0);
            rsp_valid = 1'b1; rsp_rdata = rdata; rsp_err = err;
            tick();
            rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = $urandom;
            exp_fault = err;
            exp_data  = err ? 32'd0 : (ren ? ref_load(op, lane, rdata) : alu);
        end else begin
            check("no_req", {31'd0, req_valid}, 32'd0);
            exp_fault = mis;
            exp_data  = mem ? 32'd0 : alu;
        end

        check("out_valid", {31'd0, out_valid}, 32'd1);
        check("wdata", wdata_gpr_M, exp_data);
        check("mem_fault", {31'd0, mem_fault}, {31'd0, exp_fault});
        check("ctrl_o", {8'd0, ctrl_o}, {8'd0, ctl});
        check("in_ready_busy", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < out_dly; i++) begin
            tick();
            check("hold_out_valid", {31'd0, out_valid}, 32'd1);
            check("hold_wdata", wdata_gpr_M, exp_data);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_released", {31'd0, out_valid}, 32'd0);
        check("in_ready_back", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0; mem_op = '0; addr = '0;
        store_data = '0; alu_result = '0; ctrl_i = '0; out_ready = 1'b0; req_ready = 1'b0;
        rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_req_valid", {31'd0, req_valid}, 32'd0);
        check("rst_req_we", {31'd0, req_we}, 32'd0);
        check("rst_fault", {31'd0, mem_fault}, 32'd0);
        check("rst_wstrb", {28'd0, req_wstrb}, 32'd0);
        check("rst_wdata", wdata_gpr_M, 32'd0);
        check("rst_ctrl", {8'd0, ctrl_o}, 32'd0);
        check("rst_req_addr", req_addr, 32'd0);
        check("rst_req_wdata", req_wdata, 32'd0);
        reset = 1'b0;
        tick();

        // Directed cases
        run_txn(1, 0, 3'd2, 32'h80000004, 0, 0, 24'h123456, 0, 0, 32'hDEADBEEF, 0, 0, 0);
        run_txn(1, 0, 3'd0, 32'h80000003, 0, 0, 24'h1, 1, 1, 32'h80AABBCC, 0, 0, 0);
        run_txn(1, 0, 3'd4, 32'h80000003, 0, 0, 24'h2, 0, 2, 32'h80AABBCC, 0, 0, 0);
        run_txn(1, 0, 3'd1, 32'h80000002, 0, 0, 24'h3, 0, 0, 32'h80AABBCC, 0, 1, 0);
        run_txn(1, 0, 3'd5, 32'h80000000, 0, 0, 24'h4, 2, 0, 32'h80AABBCC, 0, 0, 0);
        run_txn(0, 1, 3'd0, 32'h80000001, 32'h000000A5, 32'h77, 24'h5, 0, 0, 0, 0, 0, 0);
        run_txn(0, 1, 3'd1, 32'h80000002, 32'h00001234, 32'h88, 24'h6, 0, 1, 0, 0, 0, 0);
        run_txn(0, 0, 3'd0, 32'h0, 0, 32'h42, 24'hABCDEF, 0, 0, 0, 0, 3, 0);
        run_txn(1, 0, 3'd2, 32'h80000008, 0, 0, 24'h7, 5, 0, 32'h12345678, 1, 0, 0);
        run_txn(1, 1, 3'd2, 32'h8000000C, 32'hFFFFFFFF, 32'h99, 24'h8, 0, 0, 32'hCAFEF00D, 0, 0, 1);
        run_txn(1, 0, 3'd2, 32'h80000002, 0, 0, 24'h9, 0, 0, 32'h0BADF00D, 0, 0, 0);

        // Reset while waiting for a response
        in_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; mem_op = 3'd2; addr = 32'h80000010;
        tick();
        in_valid = 1'b0; req_ready = 1'b1;
        tick();
        req_ready = 1'b0; reset = 1'b1;
        #1;
        check("rst_wait_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_wait_idle", {31'd0, in_ready}, 32'd1);
        check("rst_wait_out", {31'd0, out_valid}, 32'd0);
        check("rst_wait_req", {31'd0, req_valid}, 32'd0);
        rsp_valid = 1'b1; rsp_rdata = 32'h55AA55AA; rsp_err = 1'b1;
        tick();
        rsp_valid = 1'b0; rsp_err = 1'b0;
        check("late_rsp_out", {31'd0, out_valid}, 32'd0);
        check("late_rsp_idle", {31'd0, in_ready}, 32'd1);
        check("late_rsp_fault", {31'd0, mem_fault}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            bit ren, wen;
            logic [2:0] op;
            int unsigned k;
            ren = 1'($urandom);
            wen = 1'($urandom);
            if (ren) begin
                k = $urandom_range(0, 4);
                op = (k < 3) ? 3'(k) : 3'(k + 1);
            end else begin
                op = 3'($urandom_range(0, 2));
            end
            run_txn(ren, wen, op, $urandom, $urandom, $urandom, CTRL_W'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 2), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
